// File: rtl/uart_receiver_if.sv
// Character hand-off between the UART receiver (master) and its consumer (slave).
interface uart_receiver_if;
    logic [7:0] dataOut;
    logic       dataValid;
    logic       dataRead;
    logic       parityError;
    logic       frameError;
    logic       overrun;

    modport master (
        output dataOut,
        output dataValid,
        output parityError,
        output frameError,
        output overrun,
        input  dataRead
    );

    modport slave (
        input  dataOut,
        input  dataValid,
        input  parityError,
        input  frameError,
        input  overrun,
        output dataRead
    );
endinterface

// File: rtl/uart_receiver.sv
// UART receive stage: synchronises rx, samples each bit mid-period, checks parity/stop
// bits and holds one received character behind a valid/read handshake.
module uart_receiver #(
    parameter int CLOCK_DIVISOR_WIDTH = 24
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           rx,
    input  logic [1:0]                     dataBits,
    input  logic                           hasParity,
    input  logic [1:0]                     parityMode,
    input  logic                           extraStopBit,
    input  logic [CLOCK_DIVISOR_WIDTH-1:0] clockDivisor,
    output logic                           busy,
    uart_receiver_if.master                rx_if
);
    localparam int CW = CLOCK_DIVISOR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4,
        S_STOP2  = 3'd5
    } state_t;

    function automatic logic expected_parity(input logic [1:0] mode, input logic [7:0] data);
        case (mode)
            2'b00:   return 1'b0;
            2'b11:   return 1'b1;
            2'b10:   return ^data;
            default: return ~(^data);
        endcase
    endfunction

    logic          r_rx_meta;
    logic          r_rxs;
    logic          r_rxs_prev;
    state_t        r_state;
    logic          r_armed;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_div;
    logic [2:0]    r_bit_cnt;
    logic [1:0]    r_data_bits;
    logic [1:0]    r_parity_mode;
    logic          r_has_parity;
    logic          r_extra_stop;
    logic [7:0]    r_shift;
    logic          r_par_err;
    logic          r_frm_err;
    logic [7:0]    r_data_out;
    logic          r_data_valid;
    logic          r_parity_error;
    logic          r_frame_error;
    logic          r_overrun;

    logic          w_start_edge;
    logic [CW-1:0] w_half_m1;
    logic          w_half_hit;
    logic          w_bit_hit;
    logic [2:0]    w_last_bit;
    logic          w_exp_parity;
    logic          w_frame_err_final;
    logic          w_complete;

    // Two-flop synchroniser plus one history flop for falling-edge detection.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_rx_meta  <= 1'b1;
            r_rxs      <= 1'b1;
            r_rxs_prev <= 1'b1;
        end else begin
            r_rx_meta  <= rx;
            r_rxs      <= r_rx_meta;
            r_rxs_prev <= r_rxs;
        end
    end

    // Sample-point decode and frame completion.
    always_comb begin
        w_start_edge      = r_armed && r_rxs_prev && !r_rxs;
        w_half_m1         = (r_div >> 1) - CW'(1'b1);
        w_half_hit        = (r_cnt == w_half_m1);
        w_bit_hit         = (r_cnt == r_div);
        w_last_bit        = {1'b0, r_data_bits} + 3'd4;
        w_exp_parity      = expected_parity(r_parity_mode, r_shift);
        w_frame_err_final = r_frm_err | ~r_rxs;
        if (w_bit_hit && ((r_state == S_STOP && !r_extra_stop) || r_state == S_STOP2)) begin
            w_complete = 1'b1;
        end else begin
            w_complete = 1'b0;
        end
    end

    // Receive FSM and single-entry holding register.
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state        <= S_IDLE;
            r_armed        <= 1'b0;
            r_cnt          <= '0;
            r_div          <= '0;
            r_bit_cnt      <= 3'd0;
            r_data_bits    <= 2'd0;
            r_parity_mode  <= 2'd0;
            r_has_parity   <= 1'b0;
            r_extra_stop   <= 1'b0;
            r_shift        <= 8'd0;
            r_par_err      <= 1'b0;
            r_frm_err      <= 1'b0;
            r_data_out     <= 8'd0;
            r_data_valid   <= 1'b0;
            r_parity_error <= 1'b0;
            r_frame_error  <= 1'b0;
            r_overrun      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_start_edge) begin
                        r_state       <= S_START;
                        r_armed       <= 1'b0;
                        r_cnt         <= '0;
                        r_bit_cnt     <= 3'd0;
                        r_div         <= clockDivisor;
                        r_data_bits   <= dataBits;
                        r_parity_mode <= parityMode;
                        r_has_parity  <= hasParity;
                        r_extra_stop  <= extraStopBit;
                        r_shift       <= 8'd0;
                        r_par_err     <= 1'b0;
                        r_frm_err     <= 1'b0;
                    end else begin
                        r_armed <= r_armed | r_rxs;
                    end
                end
                S_START: begin
                    if (w_half_hit) begin
                        r_cnt <= '0;
                        if (r_rxs) begin
                            r_state <= S_IDLE;
                            r_armed <= 1'b1;
                        end else begin
                            r_state <= S_DATA;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                S_DATA: begin
                    if (w_bit_hit) begin
                        r_cnt              <= '0;
                        r_shift[r_bit_cnt] <= r_rxs;
                        if (r_bit_cnt == w_last_bit) begin
                            r_state <= r_has_parity ? S_PARITY : S_STOP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 3'd1;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                S_PARITY: begin
                    if (w_bit_hit) begin
                        r_cnt     <= '0;
                        r_par_err <= (r_rxs != w_exp_parity);
                        r_state   <= S_STOP;
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                S_STOP: begin
                    if (w_bit_hit) begin
                        r_cnt     <= '0;
                        r_frm_err <= w_frame_err_final;
                        if (r_extra_stop) begin
                            r_state <= S_STOP2;
                        end else begin
                            r_state <= S_IDLE;
                            r_armed <= r_rxs;
                        end
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                S_STOP2: begin
                    if (w_bit_hit) begin
                        r_cnt   <= '0;
                        r_state <= S_IDLE;
                        r_armed <= r_rxs;
                    end else begin
                        r_cnt <= r_cnt + CW'(1'b1);
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_armed <= 1'b0;
                end
            endcase

            // A same-cycle read consumes the old character, so no overrun is flagged.
            if (w_complete) begin
                r_data_out     <= r_shift;
                r_parity_error <= r_par_err;
                r_frame_error  <= w_frame_err_final;
                r_data_valid   <= 1'b1;
                r_overrun      <= r_data_valid && !rx_if.dataRead;
            end else if (rx_if.dataRead && r_data_valid) begin
                r_data_valid <= 1'b0;
                r_overrun    <= 1'b0;
            end else begin
                r_data_valid <= r_data_valid;
                r_overrun    <= r_overrun;
            end
        end
    end

    assign busy              = (r_state != S_IDLE);
    assign rx_if.dataOut     = r_data_out;
    assign rx_if.dataValid   = r_data_valid;
    assign rx_if.parityError = r_parity_error;
    assign rx_if.frameError  = r_frame_error;
    assign rx_if.overrun     = r_overrun;
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Serial-to-parallel UART receive stage, the counterpart of the UART transmitter on the same link. It synchronises the asynchronous `rx` line, finds the start bit, samples each bit at mid-period and checks parity and stop bits. It then presents one received character in a single-entry holding register with a valid/read handshake. It uses the same frame configuration inputs and divisor convention as the transmitter, so one configuration source drives both ends of a loopback.

## Interface
- `CLOCK_DIVISOR_WIDTH`, 24, width of `clockDivisor`.

- `clk`  in  1  system clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-low reset.
- `rx`  in  1  asynchronous serial input; idle high.
- `dataBits`  in  2  data bit count = `dataBits` + 5.
- `hasParity`  in  1  frame carries a parity bit.
- `parityMode`  in  2  parity mode: 00 space, 11 mark, 10 even, 01 odd.
- `extraStopBit`  in  1  frame carries two stop bits.
- `clockDivisor`  in  CLOCK_DIVISOR_WIDTH  bit period = `clockDivisor` + 1 clk cycles (D below); D ≥ 3 required.
- `dataOut`  out  8  received character, LSB-first on the wire, right-aligned, unused upper bits 0.
- `dataValid`  out  1  `dataOut` and the flags hold an unread character.
- `dataRead`  in  1  consumer pulse; clears `dataValid` and `overrun`.
- `parityError`  out  1  parity mismatch in the current character; 0 when `hasParity` = 0.
- `frameError`  out  1  a stop bit of the current character sampled low.
- `overrun`  out  1  a character was overwritten before it was read.
- `busy`  out  1  state ≠ IDLE.

## Operation
- `rx` passes through a 2-FF synchroniser (`rxs`) before any use. Edge detection uses `rxs` and its previous value.
- All configuration inputs are latched on start-edge detection and held for the whole frame.
- FSM states: IDLE, START, DATA, PARITY, STOP, STOP2.
- IDLE:
  - An `armed` flag sets when `rxs` = 1.
  - A falling edge of `rxs` while `armed` goes to START and clears the bit counter and cycle counter.
- START:
  - At D>>1 cycles after the edge, sample `rxs`.
  - If 1: false start; return to IDLE with `armed` = 1.
  - Else go to DATA.
  - All later samples occur every D+1 cycles after the previous sample.
- DATA:
  - Shift in `dataBits`+5 bits, LSB first.
  - Go to PARITY if `hasParity`, else STOP.
- PARITY:
  - Expected bit: space 0, mark 1, even = XOR(data), odd = ~XOR(data).
  - Mismatch sets the frame's parity error.
- STOP:
  - Sampling 0 sets the frame error.
  - Go to STOP2 if `extraStopBit`, else complete.
- STOP2: same check as STOP, then complete.
- Complete:
  - Load `dataOut`, `parityError` and `frameError`, set `dataValid`, return to IDLE.
  - `armed` = `rxs` at that sample, so a low stop bit or break does not retrigger until the line goes high.
- Holding register:
  - `dataRead` while `dataValid` clears `dataValid` and `overrun`.
  - `dataRead` with `dataValid` = 0 is ignored.
  - Completion while `dataValid` = 1 and no `dataRead`: new character overwrites `dataOut` and the flags, `dataValid` stays 1, `overrun` = 1.
  - Completion in the same cycle as `dataRead`: new character loads, `dataValid` stays 1, `overrun` = 0.
- Counters:
  - Cycle counter is CLOCK_DIVISOR_WIDTH bits and compares against the latched divisor, so it never wraps past D.
  - Bit counter is 3 bits.

## Timing
- Reset values: `dataOut` = 0, `dataValid` = 0, `parityError` = 0, `frameError` = 0, `overrun` = 0, `busy` = 0, FSM in IDLE, `armed` = 0.
- Synchroniser FFs reset to 1.
- `rst` low mid-frame aborts the frame immediately; no partial character is ever presented.
- Edge detect occurs 2 cycles after the `rx` fall (synchroniser latency). `busy` rises the cycle after detection.
- For a frame of N = 1 + data + parity + stop bits, the final sample is at edge + D>>1 + (N−1)(D+1) cycles.
- `dataValid` and the flags update on the clk edge following the final sample.
- `busy` drops in the same cycle. A new start edge is accepted from the next cycle.
- Outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- 8N1, D = 15, send 0xA5 via bit-accurate driver → `dataValid` rises once; `dataOut` = 0xA5; all flags 0; `busy` low 1 cycle after last sample.
- 7E1 then 7O1 sending 0x55, correct parity → `dataOut` = 0x55, `parityError` = 0; flip the parity bit → `parityError` = 1, `dataOut` still 0x55.
- 5N2 0x1F with second stop bit driven 0 → `frameError` = 1. Then hold `rx` low 20 bit periods → no further `dataValid` until `rx` goes high and a new start bit arrives.
- `rx` low glitch of D>>1 − 2 cycles → `busy` pulses and returns to IDLE; `dataValid` stays 0.
- Two back-to-back 8N1 frames 0x11, 0x22 with no `dataRead` → `dataOut` = 0x22, `overrun` = 1. Then `dataRead` → `dataValid` = 0, `overrun` = 0. Repeat with `dataRead` coincident with the second completion → `overrun` = 0.
- Loopback from the UART transmitter over all 4×2×4×2 configurations, random data, D = 4 and D = 100 → every character matches, no flags. Assert `rst` low mid-frame → all outputs at reset values next cycle.
